seq_counter_mode: RTL
=====================

// Module: seq_counter_mode
// PURPOSE
//  Parametrised synchronous sequence counter built on a D-register state vector, next state chosen by mode.
//  Generalises fixed 4-bit next-state D-input logic to any WIDTH and MODULUS.
//  Modes: binary up, binary down, Gray-coded up, and Johnson or hold.
//  Used as the sequence source for datapath and control experiments.
// PARAMETERS
//  WIDTH      4   state/output width in bits, >= 2
//  MODULUS    16  binary/Gray sequence length, 2 <= MODULUS <= 2**WIDTH
//  RESET_VAL  0   count after reset, must be < MODULUS
// PORTS
//  clk   in   1      single clock, rising-edge
//  clr   in   1      reset: synchronous, active-high
//  en    in   1      count enable
//  load  in   1      parallel load strobe
//  din   in   WIDTH  load value, binary
//  mode  in   2      00 up, 01 down, 10 Gray up, 11 Johnson (macro) or hold
//  q     out  WIDTH  registered output code
//  tc    out  1      terminal count, combinational
//  wrap  out  1      registered 1-cycle pulse on sequence wrap
// BEHAVIOUR
//  - Internal register cnt[WIDTH-1:0]; all updates on posedge clk.
//  - Edge priority: clr > load > en; en=0 and load=0 -> hold, wrap<=0.
//  - clr=1: cnt<=RESET_VAL, q<=RESET_VAL (binary), wrap<=0; overrides load/en, even mid-sequence.
//  - load=1: cnt<=min(din, MODULUS-1); wrap<=0; en ignored.
//  - In Johnson mode, load applies din unclamped.
//  - Up (00): cnt==MODULUS-1 -> 0 with wrap<=1; else cnt+1.
//  - Down (01): cnt==0 -> MODULUS-1 with wrap<=1; else cnt-1.
//  - Gray (10): cnt steps as Up; q<=next^(next>>1); unit-distance across wrap only if MODULUS==2**WIDTH.
//  - q encoding is chosen by mode at the same edge: binary in 00/01, Gray in 10, raw cnt in 11.
//  - Latency: one edge from en/load/mode to q; wrap rises on the edge that enters the wrapped state.
//  - tc = en & ~load & ~clr & (cnt at terminal for current mode).
//  - Terminal state: MODULUS-1 for up/Gray, 0 for down, 1000..0 for Johnson; tc=0 in hold.
//  - Mode change: takes effect next enabled edge and continues from current cnt.
//  - Any cnt >= MODULUS on entry to 00/01/10: next enabled edge forces 0, no wrap.
//  - Arithmetic: modulo compare done in WIDTH+1 bits; no out-of-range value reaches q outside Johnson.
// CONFIGURATION
//  Macro SEQ_COUNTER_JOHNSON_EN:
//  - Defined: mode 11 = Johnson (twisted ring), 2*WIDTH states, cnt<={cnt[WIDTH-2:0],~cnt[WIDTH-1]}.
//  - Entering 11 with cnt not a valid Johnson pattern: first enabled edge loads 0, no wrap.
//  - Johnson wrap<=1 when state 10..0 -> 0.
//  - Not defined: mode 11 = hold; cnt/q unchanged, tc=0, wrap<=0; no Johnson logic synthesised.
// TESTING
//  - WIDTH=4,MODULUS=10,mode=00,en=1 from clr -> q 0..9,0; wrap=1 one cycle at the 9->0 edge.
//  - Same bench: tc=1 only while q=9.
//  - mode=01, load din=3 then en -> q 3,2,1,0,9,8; wrap pulse at 0->9.
//  - Down-mode tc=1 while q=0.
//  - MODULUS=16, mode=10 from 0 -> q 0000,0001,0011,0010,0110,0111,0101,0100,...,1000,0000.
//  - Each Gray step differs by exactly one bit.
//  - MODULUS=10: load=1,en=1,din=12 -> q=9, no increment that edge.
//  - MODULUS=10: clr=1 with load=1 at q=5 -> q=0, wrap=0.
//  - With SEQ_COUNTER_JOHNSON_EN, mode=11 from 0 -> 0000,0001,0011,0111,1111,1110,1100,1000,0000.
//  - Johnson wrap at 1000->0000.
//  - Without the macro, mode=11 holds q for 5 edges.

Source files
------------

// File: rtl/seq_counter_mode.sv
// Parametrised sequence counter: binary up, binary down, Gray up, and Johnson or hold on mode 11.
// Latency: one clk edge from en/load/mode/clr to q and wrap; tc is combinational from cnt and inputs.
// Backpressure: none; en=0 with load=0 freezes cnt and q.
// Ports: clk, clr (sync active-high), en, load, din[WIDTH], mode[2] in; q[WIDTH], tc, wrap out.
// Optional macro SEQ_COUNTER_JOHNSON_EN turns mode 11 into a twisted-ring counter instead of hold.
module seq_counter_mode #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Modulo arithmetic is done one bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   LAST_X = MOD_X - 1'b1;
    localparam logic [WIDTH-1:0] LAST   = LAST_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST    = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] din_clamped;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   din_x;
    logic             in_range;
    logic             at_last;
    logic             at_zero;
    logic             wrap_nxt;
    logic             upd;
    logic             term;

    assign cnt_x       = {1'b0, cnt};
    assign din_x       = {1'b0, din};
    assign in_range    = cnt_x < MOD_X;
    assign at_last     = cnt_x == LAST_X;
    assign at_zero     = cnt == '0;
    assign din_clamped = (din_x > LAST_X) ? LAST : din;

`ifdef SEQ_COUNTER_JOHNSON_EN
    localparam logic [WIDTH-1:0] JTERM = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] cnt_inv;
    logic             j_valid;
    logic             at_jterm;

    // Legal twisted-ring states are a run of ones anchored at the LSB
    // (0001, 0011, ...) or at the MSB (1110, 1100, ...), plus all-zero.
    assign cnt_inv  = ~cnt;
    assign j_valid  = ((cnt & (cnt + ONE)) == '0) || ((cnt_inv & (cnt_inv + ONE)) == '0);
    assign at_jterm = cnt == JTERM;
`endif

    // Next-count selection; upd says whether cnt/q move at this edge.
    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        upd      = 1'b0;
        if (load) begin
            upd     = 1'b1;
            cnt_nxt = din_clamped;
`ifdef SEQ_COUNTER_JOHNSON_EN
            if (mode == 2'b11) cnt_nxt = din;
`endif
        end else if (en) begin
            case (mode)
                2'b00, 2'b10: begin
                    upd = 1'b1;
                    if (!in_range) begin
                        cnt_nxt = '0;
                    end else if (at_last) begin
                        cnt_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                2'b01: begin
                    upd = 1'b1;
                    if (!in_range) begin
                        cnt_nxt = '0;
                    end else if (at_zero) begin
                        cnt_nxt  = LAST;
                        wrap_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                default: begin
`ifdef SEQ_COUNTER_JOHNSON_EN
                    upd = 1'b1;
                    if (!j_valid) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt  = {cnt[WIDTH-2:0], ~cnt[WIDTH-1]};
                        wrap_nxt = at_jterm;
                    end
`endif
                end
            endcase
        end
    end

    // q is re-encoded from the new count using the mode present at the same edge.
    always_comb begin
        q_nxt = cnt_nxt;
        if (mode == 2'b10) q_nxt = cnt_nxt ^ (cnt_nxt >> 1);
    end

    // Terminal-state detect for the current mode.
    always_comb begin
        term = 1'b0;
        case (mode)
            2'b00, 2'b10: term = at_last;
            2'b01:        term = at_zero;
            default: begin
`ifdef SEQ_COUNTER_JOHNSON_EN
                term = at_jterm;
`endif
            end
        endcase
    end

    assign tc = en & ~load & ~clr & term;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt  <= RST;
            q    <= RST;
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
            if (upd) begin
                cnt <= cnt_nxt;
                q   <= q_nxt;
            end
        end
    end

endmodule
